// File: rtl/apb_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one APB master port among NUM_REQ requesters.
// One command per grant: SETUP, ACCESS_CYCLES access cycles, then a one-cycle response.
module apb_txn_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       resp_err,
    output logic                       TRANSFER,
    output logic                       read,
    output logic                       write,
    output logic [ADDR_W-1:0]          apb_write_address,
    output logic [DATA_W-1:0]          apb_write_data,
    output logic [ADDR_W-1:0]          apb_read_address,
    input  logic [DATA_W-1:0]          apb_read_out,
    input  logic                       PSLVERR,
    output logic                       busy,
    output logic [7:0]                 err_count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       last_q, last_d;
    logic [IW-1:0]       win_q, win_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                xfer_q, xfer_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rerr_q, rerr_d;
    logic [7:0]          errcnt_q, errcnt_d;
    logic                busy_q, busy_d;

    logic                found;
    logic [IW-1:0]       pick;
    logic [IW-1:0]       cand;

    // Scan last+1, last+2, ... so the most recent winner has lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = last_q;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((32'(last_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        xfer_d   = xfer_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        waddr_d  = waddr_q;
        raddr_d  = raddr_q;
        wdata_d  = wdata_q;
        ready_d  = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        errcnt_d = errcnt_q;
        busy_d   = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d       = S_SETUP;
                    last_d        = pick;
                    win_d         = pick;
                    xfer_d        = 1'b1;
                    wr_d          = req_write[pick];
                    rd_d          = ~req_write[pick];
                    waddr_d       = req_addr[pick*ADDR_W +: ADDR_W];
                    raddr_d       = req_addr[pick*ADDR_W +: ADDR_W];
                    wdata_d       = req_write[pick] ? req_wdata[pick*DATA_W +: DATA_W] : '0;
                    ready_d[pick] = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = '0;
            end
            S_ACCESS: begin
                if (cnt_q == CW'(ACCESS_CYCLES - 1)) begin
                    state_d         = S_RESP;
                    xfer_d          = 1'b0;
                    rd_d            = 1'b0;
                    wr_d            = 1'b0;
                    rdata_d         = wr_q ? '0 : apb_read_out;
                    rerr_d          = PSLVERR;
                    rvalid_d[win_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (rerr_q && errcnt_q != 8'hFF) begin
                    errcnt_d = errcnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            last_q   <= IW'(NUM_REQ - 1);
            win_q    <= '0;
            cnt_q    <= '0;
            xfer_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            waddr_q  <= '0;
            raddr_q  <= '0;
            wdata_q  <= '0;
            ready_q  <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            errcnt_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            xfer_q   <= xfer_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            errcnt_q <= errcnt_d;
            busy_q   <= busy_d;
        end
    end

    assign req_ready         = ready_q;
    assign resp_valid        = rvalid_q;
    assign resp_rdata        = rdata_q;
    assign resp_err          = rerr_q;
    assign TRANSFER          = xfer_q;
    assign read              = rd_q;
    assign write             = wr_q;
    assign apb_write_address = waddr_q;
    assign apb_write_data    = wdata_q;
    assign apb_read_address  = raddr_q;
    assign busy              = busy_q;
    assign err_count         = errcnt_q;

endmodule

// File: tb/tb_apb_txn_arbiter.sv
// Scoreboard bench for apb_txn_arbiter: directed requests, queued expectations,
// negedge monitor comparing grants and responses against a small APB slave model.
module tb_apb_txn_arbiter;

    localparam int AC = 1;

    logic         PCLK = 1'b0;
    logic         PRESET;
    logic [3:0]   req_valid, req_write;
    logic [127:0] req_addr, req_wdata;
    logic [3:0]   req_ready, resp_valid;
    logic [31:0]  resp_rdata;
    logic         resp_err, TRANSFER, rd, wr, busy;
    logic [31:0]  waddr, wdata, raddr, rdout;
    logic         pslverr;
    logic [7:0]   err_count;

    // ACCESS_CYCLES=3 instance
    logic [1:0]   r3_valid, r3_write, r3_ready, r3_rv;
    logic [63:0]  r3_addr, r3_wdata;
    logic [31:0]  r3_rdata, r3_waddr, r3_wdat, r3_raddr;
    logic         r3_err, r3_xfer, r3_rd, r3_wr, r3_busy;
    logic [7:0]   r3_errcnt;

    always #5 PCLK = ~PCLK;

    apb_txn_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(AC)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .TRANSFER(TRANSFER), .read(rd), .write(wr), .apb_write_address(waddr),
        .apb_write_data(wdata), .apb_read_address(raddr), .apb_read_out(rdout),
        .PSLVERR(pslverr), .busy(busy), .err_count(err_count));

    apb_txn_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(3)) dut3 (
        .PCLK(PCLK), .PRESET(PRESET), .req_valid(r3_valid), .req_write(r3_write),
        .req_addr(r3_addr), .req_wdata(r3_wdata), .req_ready(r3_ready),
        .resp_valid(r3_rv), .resp_rdata(r3_rdata), .resp_err(r3_err),
        .TRANSFER(r3_xfer), .read(r3_rd), .write(r3_wr), .apb_write_address(r3_waddr),
        .apb_write_data(r3_wdat), .apb_read_address(r3_raddr), .apb_read_out(32'h0),
        .PSLVERR(1'b0), .busy(r3_busy), .err_count(r3_errcnt));

    // APB slave model: 512-word memory, PSLVERR on address 0x1FF
    logic [31:0] mem [512];
    always @(posedge PCLK) if (TRANSFER && wr) mem[waddr[8:0]] <= wdata;
    assign rdout   = mem[raddr[8:0]];
    assign pslverr = TRANSFER && (waddr == 32'h1FF);

    typedef struct { int idx; logic w; logic [31:0] addr; logic [31:0] wdata; } grant_t;
    typedef struct { int idx; logic [31:0] rdata; logic err; } resp_t;
    grant_t gq[$];
    resp_t  rq[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    grant_t g;
    resp_t  r;
    int     rdy_cyc = 0;
    int     xfer = 0;
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (req_ready != 4'b0) begin
                if (gq.size() == 0) begin
                    check("grant_unexpected", 128'(req_ready), 128'h0);
                end else begin
                    g = gq.pop_front();
                    check("grant_idx", 128'(req_ready), 128'(32'd1 << g.idx));
                    check("grant_bus", {TRANSFER, wr, rd, waddr, raddr, wdata},
                          {1'b1, g.w, ~g.w, g.addr, g.addr, (g.w ? g.wdata : 32'h0)});
                end
                rdy_cyc = cyc;
                xfer = 0;
            end
            if (TRANSFER) xfer++;
            if (resp_valid != 4'b0) begin
                if (rq.size() == 0) begin
                    check("resp_unexpected", 128'(resp_valid), 128'h0);
                end else begin
                    r = rq.pop_front();
                    check("resp_idx", 128'(resp_valid), 128'(32'd1 << r.idx));
                    check("resp_data_err", {resp_rdata, resp_err}, {r.rdata, r.err});
                    check("resp_xfer_cycles", 128'(xfer), 128'(1 + AC));
                    check("resp_latency", 128'(cyc - rdy_cyc), 128'(1 + AC));
                end
            end
        end
    end

    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err, input bit push_resp);
        grant_t gg;
        resp_t  rr;
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
        gg.idx = i; gg.w = w; gg.addr = a; gg.wdata = d;
        gq.push_back(gg);
        if (push_resp) begin
            rr.idx = i; rr.rdata = exp_rd; rr.err = exp_err;
            rq.push_back(rr);
        end
    endtask

    // Releases each requester on its ready pulse; returns once the block is idle.
    task automatic run(input int budget);
        int n = 0;
        int idle = 0;
        while (n < budget && idle < 2) begin
            @(negedge PCLK);
            n++;
            for (int i = 0; i < 4; i++) if (req_ready[i]) req_valid[i] = 1'b0;
            if (req_valid == 4'b0 && !busy && resp_valid == 4'b0) idle++;
            else idle = 0;
        end
        if (idle < 2) check("run_timeout", 128'(n), 128'(budget + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t0, tr, tcnt, found;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        PRESET = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        r3_valid = '0; r3_write = '0; r3_addr = '0; r3_wdata = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("reset_outs_a", {req_ready, resp_valid, resp_rdata, resp_err, TRANSFER, rd, wr, busy, err_count}, 128'h0);
        check("reset_outs_b", {waddr, wdata, raddr}, 128'h0);
        PRESET = 1'b0;

        // ACCESS_CYCLES=3: TRANSFER 4 cycles, resp 4 cycles after ready
        r3_valid[0] = 1'b1; r3_write[0] = 1'b1; r3_addr[31:0] = 32'h40; r3_wdata[31:0] = 32'h55;
        t0 = -1; tr = -1; tcnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge PCLK);
            if (r3_ready[0]) begin t0 = n; r3_valid[0] = 1'b0; end
            if (r3_xfer) tcnt++;
            if (r3_rv[0]) tr = n;
        end
        check("ac3_grant_latency", 128'(t0), 128'(0));
        check("ac3_xfer_cycles", 128'(tcnt), 128'(4));
        check("ac3_resp_latency", 128'(tr - t0), 128'(4));

        // Write then read back through another requester
        issue(0, 1'b1, 32'h005, 32'hAA, 32'h0, 1'b0, 1'b1);
        @(negedge PCLK);
        check("ready_latency", 128'(req_ready), 128'h1);
        req_valid[0] = 1'b0;
        run(40);
        issue(1, 1'b0, 32'h005, 32'h0, 32'hAA, 1'b0, 1'b1);
        run(40);

        // Simultaneous requests after req1 won: pointer at 1 -> 2,3,0 would follow;
        // reset the pointer first so the order is 0,1,2,3.
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        issue(0, 1'b1, 32'h010, 32'h11, 32'h0, 1'b0, 1'b1);
        issue(1, 1'b1, 32'h020, 32'h22, 32'h0, 1'b0, 1'b1);
        issue(2, 1'b0, 32'h010, 32'h0, 32'h11, 1'b0, 1'b1);
        issue(3, 1'b0, 32'h020, 32'h0, 32'h22, 1'b0, 1'b1);
        run(80);
        issue(0, 1'b0, 32'h005, 32'h0, 32'hAA, 1'b0, 1'b1);
        issue(2, 1'b1, 32'h030, 32'h33, 32'h0, 1'b0, 1'b1);
        run(40);

        // Error responses and saturation
        issue(0, 1'b1, 32'h1FF, 32'h77, 32'h0, 1'b1, 1'b1);
        run(40);
        check("err_count_one", 128'(err_count), 128'(1));
        for (int k = 0; k < 256; k++) begin
            issue(0, 1'b1, 32'h1FF, 32'(k), 32'h0, 1'b1, 1'b1);
            run(40);
        end
        check("err_count_sat", 128'(err_count), 128'(255));

        // Reset during ACCESS of a req1 read; then req1/req3 pending -> 1 first
        issue(1, 1'b0, 32'h005, 32'h0, 32'h0, 1'b0, 1'b0);
        found = 0;
        for (int n = 0; n < 10 && found == 0; n++) begin
            @(negedge PCLK);
            if (req_ready[1]) req_valid[1] = 1'b0;
            else if (TRANSFER) found = 1;
        end
        check("abort_reached_access", 128'(found), 128'(1));
        PRESET = 1'b1;
        @(negedge PCLK);
        check("abort_outs", {TRANSFER, rd, wr, busy, resp_valid, err_count}, 128'h0);
        issue(1, 1'b0, 32'h020, 32'h0, 32'h22, 1'b0, 1'b1);
        issue(3, 1'b0, 32'h010, 32'h0, 32'h11, 1'b0, 1'b1);
        @(negedge PCLK);
        check("abort_no_resp", 128'(resp_valid), 128'h0);
        PRESET = 1'b0;
        run(40);

        check("scoreboard_drained", 128'(gq.size() + rq.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_txn_arbiter.md
Name: apb_txn_arbiter

Overview:
Round-robin arbiter and sequencer that lets NUM_REQ independent requesters share the single APB master port of apb_top.
- Accepts one command per grant, latched from the winning requester.
- Drives TRANSFER/read/write plus address and data for exactly one setup phase and ACCESS_CYCLES access cycles.
- Returns apb_read_out and PSLVERR to the granted requester as a one-cycle response.
- Sits directly between system-level requesters (CPU shim, DMA, debug port) and apb_top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
ACCESS_CYCLES, 1, cycles TRANSFER is held after the setup cycle (>=1)

Ports:
PCLK  input  1  clock; all logic on rising edge
PRESET  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester command valid
req_write  input  NUM_REQ  1=write, 0=read
req_addr  input  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  flattened write data
req_ready  output  NUM_REQ  one-hot, one-cycle command-accepted pulse
resp_valid  output  NUM_REQ  one-hot, one-cycle response pulse
resp_rdata  output  DATA_W  read data, valid with resp_valid (0 for writes)
resp_err  output  1  PSLVERR captured for the transfer, valid with resp_valid
TRANSFER  output  1  to apb_top
read  output  1  to apb_top
write  output  1  to apb_top
apb_write_address  output  ADDR_W  to apb_top
apb_write_data  output  DATA_W  to apb_top
apb_read_address  output  ADDR_W  to apb_top
apb_read_out  input  DATA_W  from apb_top
PSLVERR  input  1  from apb_top
busy  output  1  high in any state other than IDLE
err_count  output  8  saturating count of PSLVERR responses

Behaviour:
- All outputs are registered.
- Reset: every output is 0. State=IDLE. Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first. Reset asserted mid-transfer aborts at the next edge: TRANSFER/read/write drop to 0 and no resp_valid is issued.
- FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: if any req_valid bit is set at an edge, the winner is the first set bit scanning last+1, last+2, ... modulo NUM_REQ.
  - On that edge: latch the winner's write/addr/wdata and winner index; set last=winner; go to SETUP.
  - Requests that deassert before being sampled are ignored.
- SETUP (1 cycle):
  - TRANSFER=1. write=req_write, read=~req_write. read and write are never both 1.
  - apb_write_address and apb_read_address both carry the latched address.
  - apb_write_data carries the latched wdata for writes and 0 for reads.
  - req_ready[winner]=1 this cycle only. A requester holds its command stable until it sees req_ready.
- ACCESS (ACCESS_CYCLES cycles, internal counter):
  - All apb outputs are held.
  - On the edge ending the last ACCESS cycle, capture apb_read_out (reads only, else 0) and PSLVERR, then go to RESP.
- RESP (1 cycle):
  - TRANSFER=read=write=0. Address and data outputs are held.
  - resp_valid[winner]=1 with resp_rdata and resp_err.
  - err_count increments if resp_err, saturating at 255.
  - Then go to IDLE.
- Throughput: a new grant is sampled in the first IDLE cycle after RESP. Minimum transfer period is 3+ACCESS_CYCLES cycles (4 by default). TRANSFER is high for 1+ACCESS_CYCLES consecutive cycles (20 ns at 100 MHz by default).
- Simultaneous requests: one grant per transfer. The other requesters wait; their req_valid stays high without loss.
- A requester re-requesting immediately after its own response has the lowest priority if others are pending.
- req_valid changes while the block is busy do not affect the transfer in flight.

Test Plan:
- Reset, then req0 write addr 0x005 data 0xAA -> req_ready[0] in cycle 1; TRANSFER high cycles 1-2 with write=1, apb_write_address=0x005, apb_write_data=0xAA; resp_valid[0] in cycle 3 with resp_err=0.
- req1 read 0x005 after the write -> read=1 and apb_read_address=0x005 for 2 cycles; resp_valid[1] with resp_rdata=0xAA.
- All 4 requesters valid at the same edge after reset -> grants in order 0,1,2,3, each 4 cycles apart. Then req0 and req2 valid again -> grant 0 then 2.
- req0 write to 0x1FF where apb_top raises PSLVERR -> resp_err=1 and err_count=1. 256 further error writes -> err_count stays 255.
- PRESET asserted during ACCESS -> the next edge shows TRANSFER=0, busy=0, no resp_valid. A pending req3 after release -> granted with req0-first priority restored.
- ACCESS_CYCLES=3 build -> TRANSFER high for 4 cycles; resp_valid occurs on cycle 5 after the grant edge.
